// File: rtl/wallclock_pkg.sv
// ----------------------------------------------------------------------------
// wallclock_pkg
//   Shared definitions for the wall-clock time-setting front end:
//   - state_e     : edit state machine encoding (RUN, EDIT_HR, EDIT_MIN, COMMIT)
//   - HR_MAX/MIN_MAX : BCD upper limits of the hour and minute fields
//   - BLANK_*     : per-digit blank masks, ordered {hr_l, hr_r, min_l, min_r}
//   - bcd_in_range / bcd_inc / bcd_dec : two-digit BCD helpers that keep the
//     tens and units digits separate (no binary conversion)
// ----------------------------------------------------------------------------
package wallclock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        EDIT_HR  = 2'd1,
        EDIT_MIN = 2'd2,
        COMMIT   = 2'd3
    } state_e;

    localparam logic [7:0] HR_MAX  = 8'h23;
    localparam logic [7:0] MIN_MAX = 8'h59;

    localparam logic [3:0] BLANK_NONE = 4'b0000;
    localparam logic [3:0] BLANK_HR   = 4'b1100;
    localparam logic [3:0] BLANK_MIN  = 4'b0011;

    // Both digits decimal and the pair not above the field limit. For valid
    // BCD the numeric order of the packed byte matches the decimal order.
    function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00)
            return max;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// ----------------------------------------------------------------------------
// time_set_if
//   Valid/ready load channel from the time-setting front end to the
//   timekeeping counter.
//   set_valid            : load request, time on set_* is stable while high
//   set_ready            : timekeeper accepts the load
//   set_hr_l .. set_min_r: BCD time to load
//   modport master : the front end (drives valid and data)
//   modport slave  : the timekeeper (drives ready)
// ----------------------------------------------------------------------------
interface time_set_if;
    logic       set_valid;
    logic       set_ready;
    logic [3:0] set_hr_l;
    logic [3:0] set_hr_r;
    logic [3:0] set_min_l;
    logic [3:0] set_min_r;

    modport master (
        output set_valid,
        input  set_ready,
        output set_hr_l,
        output set_hr_r,
        output set_min_l,
        output set_min_r
    );

    modport slave (
        input  set_valid,
        output set_ready,
        input  set_hr_l,
        input  set_hr_r,
        input  set_min_l,
        input  set_min_r
    );
endinterface

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
//   One push button: 2-flop synchronizer, debounce counter and rising-edge
//   press pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_i      : raw asynchronous button level
//   level_o    : debounced level
//   press_o    : one-cycle pulse on the cycle after the debounced rising edge
//   A held rising edge on btn_i gives press_o exactly DEBOUNCE_CYCLES+3
//   cycles later.
// ----------------------------------------------------------------------------
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The level only flips after the synchronized input has disagreed with it
    // for DEBOUNCE_CYCLES cycles in a row; a single agreeing cycle restarts.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_q & ~level_dly_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// ----------------------------------------------------------------------------
// time_set_ctrl
//   Button-driven time-setting front end for the wall clock. Debounces the
//   mode/up/down buttons, runs the hour/minute edit state machine, and loads
//   the edited BCD time into the timekeeper over a valid/ready handshake.
//
//   CLK100MHZ, RESETN : clock, asynchronous active-low reset
//   button[2:0]       : raw buttons, [0]=mode [1]=up [2]=down
//   cur_*             : current BCD time from the timekeeper
//   set_if (master)   : load channel, set_valid/set_ready + BCD time
//   editing           : high in any edit or commit state
//   blank_mask        : per-digit blank {hr_l,hr_r,min_l,min_r}; flashes the
//                       field being edited
//
//   Build option: define TIME_SET_AUTOREPEAT_EN to generate repeat up/down
//   pulses while the button stays held in an edit state (first after
//   REPEAT_DELAY_CYCLES, then every REPEAT_PERIOD_CYCLES). Without it each
//   press yields exactly one step and the REPEAT_* parameters are unused.
//
//   set_* always mirror the edit registers; they are only meaningful to the
//   timekeeper while set_valid is high, and nothing changes them in COMMIT.
// ----------------------------------------------------------------------------
module time_set_ctrl
    import wallclock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = 2_000_000,
    parameter int BLINK_CYCLES         = 25_000_000,
    parameter int TIMEOUT_CYCLES       = 1_000_000_000,
    parameter int REPEAT_DELAY_CYCLES  = 50_000_000,
    parameter int REPEAT_PERIOD_CYCLES = 10_000_000
) (
    input  logic               CLK100MHZ,
    input  logic               RESETN,
    input  logic [2:0]         button,
    input  logic [3:0]         cur_hr_l,
    input  logic [3:0]         cur_hr_r,
    input  logic [3:0]         cur_min_l,
    input  logic [3:0]         cur_min_r,
    time_set_if.master         set_if,
    output logic               editing,
    output logic [3:0]         blank_mask
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

    logic [2:0] btn_level;
    logic [2:0] btn_press;

    for (genvar i = 0; i < 3; i++) begin : g_db
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (CLK100MHZ),
            .rst_n   (RESETN),
            .btn_i   (button[i]),
            .level_o (btn_level[i]),
            .press_o (btn_press[i])
        );
    end

    state_e          state_q, state_d;
    logic [7:0]      hr_q, hr_d;
    logic [7:0]      min_q, min_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
    logic            bl_hide_q, bl_hide_d;

    logic mode_p, up_p, down_p;
    logic in_edit, next_in_edit, enter_edit;
    logic any_press, timeout_hit;
    logic step_up, step_down;
    logic unused_ok;

    assign in_edit = (state_q == EDIT_HR) || (state_q == EDIT_MIN);
    assign mode_p  = btn_press[0];

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                            REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;
    localparam logic [RP_W-1:0] RP_DELAY_LAST  = RP_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_PERIOD_LAST = RP_W'(REPEAT_PERIOD_CYCLES - 1);

    // Index 0 = up, 1 = down. rp_arm_q selects between the initial hold
    // delay and the steady repeat period.
    logic [1:0][RP_W-1:0] rp_cnt_q, rp_cnt_d;
    logic [1:0]           rp_arm_q, rp_arm_d;
    logic [1:0]           rp_fire;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rp_fire[i]  = 1'b0;
            rp_arm_d[i] = rp_arm_q[i];
            rp_cnt_d[i] = rp_cnt_q[i] + 1'b1;
            if (!in_edit || !btn_level[i+1] || btn_press[i+1]) begin
                rp_cnt_d[i] = '0;
                rp_arm_d[i] = 1'b0;
            end else if (!rp_arm_q[i] && rp_cnt_q[i] == RP_DELAY_LAST) begin
                rp_fire[i]  = 1'b1;
                rp_cnt_d[i] = '0;
                rp_arm_d[i] = 1'b1;
            end else if (rp_arm_q[i] && rp_cnt_q[i] == RP_PERIOD_LAST) begin
                rp_fire[i]  = 1'b1;
                rp_cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge RESETN) begin
        if (!RESETN) begin
            rp_cnt_q <= '0;
            rp_arm_q <= '0;
        end else begin
            rp_cnt_q <= rp_cnt_d;
            rp_arm_q <= rp_arm_d;
        end
    end

    assign up_p      = btn_press[1] | rp_fire[0];
    assign down_p    = btn_press[2] | rp_fire[1];
    assign unused_ok = btn_level[0];
`else
    assign up_p      = btn_press[1];
    assign down_p    = btn_press[2];
    assign unused_ok = (^btn_level) ^ (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES);
`endif

    // Simultaneous up and down cancel; mode takes priority over both.
    assign step_up     = up_p & ~down_p;
    assign step_down   = down_p & ~up_p;
    assign any_press   = mode_p | up_p | down_p;
    assign timeout_hit = in_edit && !any_press && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        hr_d    = hr_q;
        min_d   = min_q;
        case (state_q)
            RUN: begin
                if (mode_p) begin
                    // Out-of-range input from the timekeeper is replaced by 00
                    // so the edit registers never hold invalid BCD.
                    hr_d    = bcd_in_range({cur_hr_l, cur_hr_r}, HR_MAX) ?
                              {cur_hr_l, cur_hr_r} : 8'h00;
                    min_d   = bcd_in_range({cur_min_l, cur_min_r}, MIN_MAX) ?
                              {cur_min_l, cur_min_r} : 8'h00;
                    state_d = EDIT_HR;
                end
            end
            EDIT_HR: begin
                if (timeout_hit)
                    state_d = RUN;
                else if (mode_p)
                    state_d = EDIT_MIN;
                else if (step_up)
                    hr_d = bcd_inc(hr_q, HR_MAX);
                else if (step_down)
                    hr_d = bcd_dec(hr_q, HR_MAX);
            end
            EDIT_MIN: begin
                if (timeout_hit)
                    state_d = RUN;
                else if (mode_p)
                    state_d = COMMIT;
                else if (step_up)
                    min_d = bcd_inc(min_q, MIN_MAX);
                else if (step_down)
                    min_d = bcd_dec(min_q, MIN_MAX);
            end
            COMMIT: begin
                if (set_if.set_ready)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign next_in_edit = (state_d == EDIT_HR) || (state_d == EDIT_MIN);
    assign enter_edit   = next_in_edit && (state_d != state_q);

    always_comb begin
        if (!in_edit || any_press || timeout_hit)
            to_cnt_d = '0;
        else
            to_cnt_d = to_cnt_q + 1'b1;

        // Blink restarts visible on every field change so the newly selected
        // field is shown before it first flashes.
        bl_cnt_d  = bl_cnt_q + 1'b1;
        bl_hide_d = bl_hide_q;
        if (!next_in_edit || enter_edit) begin
            bl_cnt_d  = '0;
            bl_hide_d = 1'b0;
        end else if (bl_cnt_q == BL_LAST) begin
            bl_cnt_d  = '0;
            bl_hide_d = ~bl_hide_q;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= RUN;
            hr_q      <= 8'h00;
            min_q     <= 8'h00;
            to_cnt_q  <= '0;
            bl_cnt_q  <= '0;
            bl_hide_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hr_q      <= hr_d;
            min_q     <= min_d;
            to_cnt_q  <= to_cnt_d;
            bl_cnt_q  <= bl_cnt_d;
            bl_hide_q <= bl_hide_d;
        end
    end

    // Outputs decode straight from reset flops so RESETN clears them at once.
    always_comb begin
        blank_mask = BLANK_NONE;
        if (bl_hide_q) begin
            if (state_q == EDIT_HR)
                blank_mask = BLANK_HR;
            else if (state_q == EDIT_MIN)
                blank_mask = BLANK_MIN;
        end
    end

    assign editing          = (state_q != RUN);
    assign set_if.set_valid = (state_q == COMMIT);
    assign set_if.set_hr_l  = hr_q[7:4];
    assign set_if.set_hr_r  = hr_q[3:0];
    assign set_if.set_min_l = min_q[7:4];
    assign set_if.set_min_r = min_q[3:0];

endmodule

// File: tb/tb_time_set_ctrl.sv
// ----------------------------------------------------------------------------
// tb_time_set_ctrl
//   Directed bench for time_set_ctrl with short debounce/blink/timeout
//   parameters. Expected values are hand-computed from the button timing:
//   a press driven at a falling edge updates the state at the 8th following
//   rising edge (2 sync + 4 debounce + 1 edge register + 1 update).
// ----------------------------------------------------------------------------
module tb_time_set_ctrl;

    localparam int DB  = 4;
    localparam int BL  = 8;
    localparam int TO  = 200;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int LAT = DB + 4;

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam logic [15:0] HOLD_EXP = 16'h1000;
`else
    localparam logic [15:0] HOLD_EXP = 16'h0600;
`endif

    logic       clk;
    logic       rst_n;
    logic [2:0] button;
    logic [3:0] cur_hr_l, cur_hr_r, cur_min_l, cur_min_r;
    logic       editing;
    logic [3:0] blank_mask;

    int n_tests;
    int n_fail;

    time_set_if set_bus ();

    time_set_ctrl #(
        .DEBOUNCE_CYCLES      (DB),
        .BLINK_CYCLES         (BL),
        .TIMEOUT_CYCLES       (TO),
        .REPEAT_DELAY_CYCLES  (RD),
        .REPEAT_PERIOD_CYCLES (RP)
    ) dut (
        .CLK100MHZ  (clk),
        .RESETN     (rst_n),
        .button     (button),
        .cur_hr_l   (cur_hr_l),
        .cur_hr_r   (cur_hr_r),
        .cur_min_l  (cur_min_l),
        .cur_min_r  (cur_min_r),
        .set_if     (set_bus),
        .editing    (editing),
        .blank_mask (blank_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] shown();
        return {set_bus.set_hr_l, set_bus.set_hr_r, set_bus.set_min_l, set_bus.set_min_r};
    endfunction

    task automatic set_cur(input logic [15:0] t);
        {cur_hr_l, cur_hr_r, cur_min_l, cur_min_r} = t;
    endtask

    task automatic push(input int idx);
        @(negedge clk);
        button[idx] = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
    endtask

    task automatic release_btn(input int idx);
        @(negedge clk);
        button[idx] = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
    endtask

    task automatic press(input int idx);
        push(idx);
        release_btn(idx);
    endtask

    int  k;
    logic sv_seen;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        button  = 3'b000;
        set_bus.set_ready = 1'b1;
        set_cur(16'h1234);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst editing", editing, 1'b0);
        chk("rst set_valid", set_bus.set_valid, 1'b0);
        chk("rst blank", blank_mask, 4'b0000);
        chk("rst set_time", shown(), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Enter EDIT_HR capturing 12:34
        push(0);
        chk("enter editing", editing, 1'b1);
        chk("enter capture", shown(), 16'h1234);
        chk("enter blank visible", blank_mask, 4'b0000);
        release_btn(0);
        chk("blink hr hidden", blank_mask, 4'b1100);

        // Bounce on up: only the final held edge counts
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            button[1] = (i % 2 == 0);
            repeat (2) @(posedge clk);
        end
        @(negedge clk);
        button[1] = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (set_bus.set_hr_r != 4'd2) break;
        end
        chk("bounce latency", k, LAT);
        repeat (10) @(posedge clk);
        #1;
        chk("bounce single step", shown(), 16'h1334);
        release_btn(1);

        // 11 more ups: 13 -> 24 wraps to 00
        for (int i = 0; i < 11; i++) press(1);
        chk("hr after 12 ups", shown(), 16'h0034);
        press(0);
        for (int i = 0; i < 35; i++) press(2);
        chk("min after 35 downs", shown(), 16'h0059);

        // Commit with ready already high: single-cycle handshake
        push(0);
        chk("commit valid", set_bus.set_valid, 1'b1);
        chk("commit time", shown(), 16'h0059);
        @(posedge clk);
        #1;
        chk("commit valid drop", set_bus.set_valid, 1'b0);
        chk("commit back to run", editing, 1'b0);
        release_btn(0);

        // Wrap checks from 23:59
        set_cur(16'h2359);
        press(0);
        chk("wrap capture", shown(), 16'h2359);
        press(1);
        chk("hr 23 up", shown(), 16'h0059);
        press(2);
        chk("hr 00 down", shown(), 16'h2359);
        press(0);
        chk("min blank phase", blank_mask, 4'b0011);
        press(1);
        chk("min 59 up", shown(), 16'h2300);
        press(2);
        chk("min 00 down", shown(), 16'h2359);
        @(negedge clk);
        button[1] = 1'b1;
        button[2] = 1'b1;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        button[1] = 1'b0;
        button[2] = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        chk("up+down ignored", shown(), 16'h2359);

        // Commit held by ready=0 while up is pressed
        set_bus.set_ready = 1'b0;
        push(0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) button[0] = 1'b0;
            if (i == 5) button[1] = 1'b1;
            if (i == 20) button[1] = 1'b0;
            @(posedge clk);
            #1;
            chk("hold valid", set_bus.set_valid, 1'b1);
            chk("hold time", shown(), 16'h2359);
        end
        @(negedge clk);
        set_bus.set_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("late ready drop", set_bus.set_valid, 1'b0);
        chk("late ready run", editing, 1'b0);
        repeat (10) @(posedge clk);

        // Timeout in EDIT_MIN with blink checks
        set_cur(16'h0815);
        press(0);
        push(0);
        chk("to entry blank", blank_mask, 4'b0000);
        release_btn(0);
        k = 0;
        sv_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            k++;
            sv_seen = sv_seen | set_bus.set_valid;
            if (!editing) break;
            chk("to blink", blank_mask, (((8 + k) / 8) % 2 == 1) ? 4'b0011 : 4'b0000);
        end
        chk("timeout cycles", k, 192);
        chk("timeout no commit", sv_seen, 1'b0);
        chk("timeout blank", blank_mask, 4'b0000);

        // Long hold of up in EDIT_HR
        set_cur(16'h0500);
        press(0);
        @(negedge clk);
        button[1] = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        button[1] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("hold up result", shown(), HOLD_EXP);

        // Asynchronous reset mid-edit
        chk("pre reset editing", editing, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst editing", editing, 1'b0);
        chk("async rst valid", set_bus.set_valid, 1'b0);
        chk("async rst blank", blank_mask, 4'b0000);
        chk("async rst time", shown(), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Button-driven time-setting front end for the wall clock. It debounces the three push buttons and runs an hour/minute edit state machine. It then delivers a new BCD time to the timekeeping counter over a valid/ready load handshake. It sits between the raw board buttons and the timekeeper, and also supplies a blink mask to the seven-segment path so the field being edited flashes.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 2_000_000, consecutive stable cycles before a button change is accepted (20 ms at 100 MHz)
- BLINK_CYCLES, 25_000_000, half-period of edit-field blink (2 Hz)
- TIMEOUT_CYCLES, 1_000_000_000, idle cycles in an edit state before the edit is abandoned (10 s)
- REPEAT_DELAY_CYCLES, 50_000_000, hold time before auto-repeat starts (macro-gated)
- REPEAT_PERIOD_CYCLES, 10_000_000, auto-repeat interval (macro-gated)

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz
- RESETN  in  1  asynchronous, active-low reset
- button  in  3  raw, asynchronous; [0]=mode, [1]=up, [2]=down
- cur_hr_l, cur_hr_r, cur_min_l, cur_min_r  in  4 each  current BCD time from the timekeeper
- set_valid  out  1  load request; new time is on set_* outputs
- set_ready  in  1  timekeeper accepts the load
- set_hr_l, set_hr_r, set_min_l, set_min_r  out  4 each  BCD time to load
- editing  out  1  high in any edit or commit state
- blank_mask  out  4  per-digit blank for display, {hr_l,hr_r,min_l,min_r}

## Operation
- Each button: 2-flop synchronizer, then a debouncer. The debounced level flips after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears the count. A one-cycle press pulse fires on the cycle after the debounced rising edge.
- States: RUN, EDIT_HR, EDIT_MIN, COMMIT.
- RUN: a mode press captures the cur_* inputs into the edit registers and moves to EDIT_HR.
- EDIT_HR:
  - up increments the hour, 23 wraps to 00.
  - down decrements the hour, 00 wraps to 23.
  - mode moves to EDIT_MIN.
- EDIT_MIN: up and down work the same way over 00..59 with wrap. mode moves to COMMIT.
- Edit registers stay valid BCD at all times. Tens and units are handled as separate digits; no binary-to-BCD conversion.
- Up and down pulsing in the same cycle: both are ignored.
- COMMIT: set_valid=1 and set_* hold the edit registers. All buttons are ignored. When set_valid&&set_ready, the handshake completes and the state returns to RUN.
- Timeout: a counter clears on any press. In EDIT_HR or EDIT_MIN, reaching TIMEOUT_CYCLES-1 returns the state to RUN with no commit. COMMIT does not time out.
- blank_mask:
  - The blink phase toggles every BLINK_CYCLES and restarts (phase=visible) on entry to each edit state.
  - While the phase is hidden, the mask bits for the edited field are 1: 4'b1100 for hours, 4'b0011 for minutes.
  - In RUN and COMMIT the mask is 0.
- editing = (state != RUN).

## Timing
- Reset values: state=RUN, set_valid=0, set_* and edit registers=0, editing=0, blank_mask=0, debounced levels=0, all counters=0.
- Press latency: a raw rising edge held stable produces a pulse exactly DEBOUNCE_CYCLES+3 cycles later (2 sync cycles, DEBOUNCE_CYCLES count, 1 edge register).
- Press pulse to state or register update: 1 cycle.
- set_valid rises the cycle after the mode pulse in EDIT_MIN.
- set_* are stable while set_valid=1.
- set_valid falls the cycle after the handshake.
- set_ready may be high in advance; the handshake then completes in the first COMMIT cycle.
- RESETN asserted mid-edit or mid-commit: the state returns to RUN immediately and the edit is discarded; set_valid drops asynchronously.

## Configuration
- TIME_SET_AUTOREPEAT_EN defined: while up or down is held debounced-high in an edit state, extra press pulses are generated. The first comes REPEAT_DELAY_CYCLES after the initial pulse, then one every REPEAT_PERIOD_CYCLES until release. Repeat pulses also reset the timeout.
- Not defined: exactly one pulse per press; REPEAT_* parameters are unused.

## Structure
- Shared package wallclock_pkg:
  - state enum (RUN, EDIT_HR, EDIT_MIN, COMMIT)
  - BCD limits HR_MAX=23, MIN_MAX=59
  - blank-mask constants for the hour and minute fields
- Sub-module button_debounce (synchronizer, debounce counter, rising-edge pulse), instantiated three times.
- FSM, edit registers, blink and timeout counters live in the top level.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, TIMEOUT_CYCLES=200, REPEAT_DELAY_CYCLES=20, REPEAT_PERIOD_CYCLES=5.
- Bounce: toggle button[1] every 2 cycles for 20 cycles, then hold high → exactly one pulse, 7 cycles after the final edge.
- cur=12:34; press mode, up ×12, mode, down ×35, mode; set_ready=1 → one handshake with set_* = 00:59, then RUN.
- Hour wrap: in EDIT_HR at 23, press up → 00; press down → 23. Minute wrap: at 59 up → 00.
- Hold set_ready=0 for 30 cycles in COMMIT while pressing up → set_valid and set_* stay constant; raise set_ready → set_valid low the next cycle.
- Enter EDIT_MIN, no presses for 200 cycles → RUN with no set_valid; blank_mask=4'b0011 on alternate 8-cycle windows beforehand.
- Assert RESETN low in EDIT_HR → all outputs at reset values the same cycle. With TIME_SET_AUTOREPEAT_EN, hold up 40 cycles in EDIT_HR → 1+4 increments.
